// File: rtl/extreme_value_tracker.sv
// extreme_value_tracker: per-frame running max/min of valid samples with the index where it occurred
module extreme_value_tracker #(
  parameter int DATA_W = 8,
  parameter int NUM_SAMPLES = 20,
  parameter bit TIE_LAST = 1'b1,
  localparam int IDX_W = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] inp,
  input  logic              valid_signal,
  output logic              ready,
  output logic              done_signal,
  output logic [DATA_W-1:0] largest_num,
  output logic [IDX_W-1:0]  result_idx,
  output logic [IDX_W-1:0]  sample_cnt
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state, state_next;
  logic mode_q, accept, last, better, tie;
  // qualify samples: start wins over a coincident valid beat
  always_comb begin
    accept = state == COLLECT && valid_signal && !start;
    last = sample_cnt == IDX_W'(NUM_SAMPLES - 1);
    better = mode_q ? inp < largest_num : inp > largest_num;
    tie = inp == largest_num;
  end
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_next;
  // next state: start always (re)arms, the last accepted beat completes the frame
  always_comb
    state_next = start ? COLLECT : (accept && last) ? DONE : state;
  // outputs decoded from state
  always_comb
    ready = state == COLLECT;
  // datapath: frame clear on start, running extreme update on each accepted beat
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= 1'b0;
      largest_num <= '0;
      result_idx <= '0;
      sample_cnt <= '0;
      done_signal <= 1'b0;
    end else if (start) begin
      mode_q <= mode;
      largest_num <= '0;
      result_idx <= '0;
      sample_cnt <= '0;
      done_signal <= 1'b0;
    end else if (accept) begin
      if (sample_cnt == '0 || better) begin
        largest_num <= inp;
        result_idx <= sample_cnt;
      end else if (TIE_LAST && tie) begin
        result_idx <= sample_cnt;
      end
      sample_cnt <= sample_cnt + 1'b1;
      if (last) done_signal <= 1'b1;
    end
  end
endmodule
